rtc_ts_multi: RTL and testbench

RTC_TS_MULTI -- requirements
Module: rtc_ts_multi

---
 rtl/rtc_ts_multi_if.sv | 24 ++
 rtl/rtc_ts_multi.sv | 224 ++++++++++++++++++++++
 tb/tb_rtc_ts_multi.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_ts_multi_if.sv
// CPU register-write port of the timestamp unit, plus the snapshot readback it loads.
interface rtc_ts_multi_if;
    logic        we;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [19:0] snap_usec;
    logic [31:0] snap_sec;

    modport master (
        output we,
        output wa,
        output wd,
        input  snap_usec,
        input  snap_sec
    );

    modport slave (
        input  we,
        input  wa,
        input  wd,
        output snap_usec,
        output snap_sec
    );
endinterface

// File: rtl/rtc_ts_multi.sv
// Phase-accumulator driven usec/sec real-time clock with CPU set/correct/snapshot
// and NUM_CH independent rising-edge timestamp capture channels.
module rtc_ts_multi #(
    parameter int          NUM_CH   = 4,
    parameter int          ACC_W    = 32,
    parameter logic [63:0] NOM_INC  = 64'd42949673,
    parameter int          USEC_MAX = 999999
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    rtc_ts_multi_if.slave        bus,
    output logic [19:0]          usec,
    output logic [31:0]          sec,
    output logic                 pps,
    output logic                 enabled,
    input  logic [NUM_CH-1:0]    ev,
    input  logic [NUM_CH-1:0]    ev_ack,
    output logic [NUM_CH-1:0]    ev_valid,
    output logic [NUM_CH-1:0]    ev_ovf,
    output logic [NUM_CH*32-1:0] ev_sec,
    output logic [NUM_CH*20-1:0] ev_usec
);
    localparam logic [ACC_W-1:0] INC_NOM   = NOM_INC[ACC_W-1:0];
    localparam logic [19:0]      USEC_LAST = 20'(USEC_MAX);

    typedef enum logic [1:0] {
        ST_OFF      = 2'b00,
        ST_OFF_PEND = 2'b01,
        ST_RUN      = 2'b10,
        ST_RUN_PEND = 2'b11
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   apply_set;

    logic [ACC_W-1:0] acc_reg;
    logic             tick_reg;
    logic [19:0]      usec_reg;
    logic [31:0]      sec_reg;
    logic             pps_reg;
    logic [19:0]      wusec_reg;
    logic [31:0]      wsec_reg;
    logic [15:0]      corr_reg;
    logic [19:0]      snap_usec_reg;
    logic [31:0]      snap_sec_reg;

    logic wr_usec;
    logic wr_set;
    logic wr_corr;
    logic wr_snap;

    assign wr_usec = bus.we && (bus.wa == 2'd0);
    assign wr_set  = bus.we && (bus.wa == 2'd1);
    assign wr_corr = bus.we && (bus.wa == 2'd2);
    assign wr_snap = bus.we && (bus.wa == 2'd3);

    assign enabled = (state_reg == ST_RUN) || (state_reg == ST_RUN_PEND);

    // Set/enable control: the *_PEND states hold an armed set that has not been applied yet.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_OFF;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        apply_set  = 1'b0;
        case (state_reg)
            ST_OFF: begin
                if (wr_set) begin
                    state_next = ST_OFF_PEND;
                end
            end
            ST_OFF_PEND: begin
                if (!wr_set) begin
                    apply_set  = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wr_set) begin
                    state_next = ST_RUN_PEND;
                end
            end
            ST_RUN_PEND: begin
                // A fresh set write in the tick cycle pushes the apply to a later tick.
                if (tick_reg && !wr_set) begin
                    apply_set  = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_OFF;
            end
        endcase
    end

    logic [ACC_W-1:0] corr_ext;
    logic [ACC_W-1:0] inc_eff;
    logic [ACC_W:0]   acc_sum;

    assign corr_ext = {{(ACC_W-16){corr_reg[15]}}, corr_reg};
    assign inc_eff  = INC_NOM + corr_ext;
    assign acc_sum  = {1'b0, acc_reg} + {1'b0, inc_eff};

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (apply_set || !enabled) begin
            acc_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            acc_reg  <= acc_sum[ACC_W-1:0];
            tick_reg <= acc_sum[ACC_W];
        end
    end

    logic rollover;
    assign rollover = tick_reg && !apply_set && (usec_reg == USEC_LAST);

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            usec_reg <= '0;
            sec_reg  <= '0;
            pps_reg  <= 1'b0;
        end else begin
            pps_reg <= rollover;
            if (apply_set) begin
                usec_reg <= wusec_reg;
                sec_reg  <= wsec_reg;
            end else if (tick_reg) begin
                if (usec_reg == USEC_LAST) begin
                    usec_reg <= '0;
                    sec_reg  <= sec_reg + 32'd1;
                end else begin
                    usec_reg <= usec_reg + 20'd1;
                end
            end
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            wusec_reg     <= '0;
            wsec_reg      <= '0;
            corr_reg      <= '0;
            snap_usec_reg <= '0;
            snap_sec_reg  <= '0;
        end else begin
            if (wr_usec) begin
                wusec_reg <= bus.wd[19:0];
            end
            if (wr_set) begin
                wsec_reg <= bus.wd;
            end
            if (wr_corr) begin
                corr_reg <= bus.wd[15:0];
            end
            if (wr_snap) begin
                snap_usec_reg <= usec_reg;
                snap_sec_reg  <= sec_reg;
            end
        end
    end

    assign usec          = usec_reg;
    assign sec           = sec_reg;
    assign pps           = pps_reg;
    assign bus.snap_usec = snap_usec_reg;
    assign bus.snap_sec  = snap_sec_reg;

    logic [NUM_CH-1:0] ev_d_reg;
    logic [NUM_CH-1:0] ev_edge;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            ev_d_reg <= '0;
        end else begin
            ev_d_reg <= ev;
        end
    end

    assign ev_edge = ev & ~ev_d_reg;

    // Each channel holds its first unacknowledged capture; later edges only flag overflow.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [31:0] cap_sec_reg;
            logic [19:0] cap_usec_reg;
            logic        valid_reg;
            logic        ovf_reg;

            always_ff @(posedge mclk or negedge rst_n) begin
                if (!rst_n) begin
                    cap_sec_reg  <= '0;
                    cap_usec_reg <= '0;
                    valid_reg    <= 1'b0;
                    ovf_reg      <= 1'b0;
                end else if (ev_edge[gi] && (!valid_reg || ev_ack[gi])) begin
                    cap_sec_reg  <= sec_reg;
                    cap_usec_reg <= usec_reg;
                    valid_reg    <= 1'b1;
                    ovf_reg      <= 1'b0;
                end else if (ev_edge[gi]) begin
                    ovf_reg <= 1'b1;
                end else if (ev_ack[gi]) begin
                    valid_reg <= 1'b0;
                    ovf_reg   <= 1'b0;
                end
            end

            assign ev_valid[gi]          = valid_reg;
            assign ev_ovf[gi]            = ovf_reg;
            assign ev_sec[gi*32 +: 32]   = cap_sec_reg;
            assign ev_usec[gi*20 +: 20]  = cap_usec_reg;
        end
    endgenerate
endmodule

// File: tb/tb_rtc_ts_multi.sv
// Scoreboard bench for rtc_ts_multi: fast tick (every 2 cycles), 10 usec per second.
module tb_rtc_ts_multi;
    localparam int          NUM_CH   = 4;
    localparam int          ACC_W    = 32;
    localparam logic [63:0] NOM_INC  = 64'h0000_0000_8000_0000;
    localparam int          USEC_MAX = 9;
    localparam int          CORR_N   = 49152;

    logic                 mclk  = 1'b0;
    logic                 rst_n = 1'b0;
    logic [19:0]          usec;
    logic [31:0]          sec;
    logic                 pps;
    logic                 enabled;
    logic [NUM_CH-1:0]    ev     = '0;
    logic [NUM_CH-1:0]    ev_ack = '0;
    logic [NUM_CH-1:0]    ev_valid;
    logic [NUM_CH-1:0]    ev_ovf;
    logic [NUM_CH*32-1:0] ev_sec;
    logic [NUM_CH*20-1:0] ev_usec;

    rtc_ts_multi_if bus ();

    rtc_ts_multi #(
        .NUM_CH   (NUM_CH),
        .ACC_W    (ACC_W),
        .NOM_INC  (NOM_INC),
        .USEC_MAX (USEC_MAX)
    ) dut (
        .mclk     (mclk),
        .rst_n    (rst_n),
        .bus      (bus),
        .usec     (usec),
        .sec      (sec),
        .pps      (pps),
        .enabled  (enabled),
        .ev       (ev),
        .ev_ack   (ev_ack),
        .ev_valid (ev_valid),
        .ev_ovf   (ev_ovf),
        .ev_sec   (ev_sec),
        .ev_usec  (ev_usec)
    );

    always #5 mclk = ~mclk;

    int n_cmp   = 0;
    int n_err   = 0;
    int cyc_n   = 0;
    int apply_n = 0;

    always @(posedge mclk) cyc_n <= cyc_n + 1;

    typedef struct {
        logic [19:0] u;
        logic [31:0] s;
        logic        p;
    } cnt_t;

    typedef struct {
        int          ch;
        logic [19:0] u;
        logic [31:0] s;
    } cap_t;

    cnt_t cnt_q[$];
    cap_t cap_q[$];

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.we = 1'b1;
        bus.wa = a;
        bus.wd = d;
        cyc();
        bus.we = 1'b0;
        bus.wa = 2'd0;
        bus.wd = 32'd0;
    endtask

    // Expected running time k edges after a set applied (u0, s0), nominal rate.
    function automatic cnt_t time_at(input int k, input int u0, input logic [31:0] s0);
        cnt_t r;
        int   t;
        t   = (k <= 0) ? 0 : (k - 1) / 2;
        t   = t + u0;
        r.u = 20'(t % (USEC_MAX + 1));
        r.s = s0 + 32'(t / (USEC_MAX + 1));
        r.p = 1'b0;
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(2);
        n_cmp++;
        if ({usec, sec} !== 52'd0) begin
            n_err++;
            $display("FAIL reset_time: usec=%0d sec=%h required 0/0", usec, sec);
        end
        n_cmp++;
        if ({enabled, pps} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_flags: enabled=%b pps=%b required 0/0", enabled, pps);
        end
        n_cmp++;
        if ({ev_valid, ev_ovf} !== '0) begin
            n_err++;
            $display("FAIL reset_ev: valid=%b ovf=%b required 0/0", ev_valid, ev_ovf);
        end
        @(negedge mclk);
        rst_n = 1'b1;
        cyc();
        $display("reset: usec=%0d sec=%h enabled=%b", usec, sec, enabled);
    endtask

    task automatic test_set();
        cnt_t e;
        wr(2'd0, 32'd7);
        wr(2'd1, 32'h100);
        n_cmp++;
        if ({enabled, usec} !== 21'd0) begin
            n_err++;
            $display("FAIL set_write_cycle: enabled=%b usec=%0d required 0/0", enabled, usec);
        end
        cnt_q.push_back('{20'd7, 32'h100, 1'b0});
        cnt_q.push_back('{20'd7, 32'h100, 1'b0});
        cnt_q.push_back('{20'd7, 32'h100, 1'b0});
        cnt_q.push_back('{20'd8, 32'h100, 1'b0});
        cnt_q.push_back('{20'd8, 32'h100, 1'b0});
        cnt_q.push_back('{20'd9, 32'h100, 1'b0});
        cnt_q.push_back('{20'd9, 32'h100, 1'b0});
        cnt_q.push_back('{20'd0, 32'h101, 1'b1});
        cnt_q.push_back('{20'd0, 32'h101, 1'b0});
        for (int i = 0; i < 9; i++) begin
            cyc();
            e = cnt_q.pop_front();
            $display("set k=%0d usec=%0d sec=%h pps=%b", i, usec, sec, pps);
            n_cmp++;
            if (usec !== e.u) begin
                n_err++;
                $display("FAIL set_usec k=%0d: got %0d required %0d", i, usec, e.u);
            end
            n_cmp++;
            if (sec !== e.s) begin
                n_err++;
                $display("FAIL set_sec k=%0d: got %h required %h", i, sec, e.s);
            end
            n_cmp++;
            if (pps !== e.p) begin
                n_err++;
                $display("FAIL set_pps k=%0d: got %b required %b", i, pps, e.p);
            end
        end
        n_cmp++;
        if (enabled !== 1'b1) begin
            n_err++;
            $display("FAIL set_enabled: got %b required 1", enabled);
        end
    endtask

    task automatic test_wrap();
        cnt_t e;
        bit   found;
        found = 1'b0;
        wr(2'd0, 32'd9);
        wr(2'd1, 32'hFFFF_FFFF);
        for (int i = 0; i < 12 && !found; i++) begin
            cyc();
            if (sec === 32'hFFFF_FFFF) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL wrap_apply: sec=%h required ffffffff within 12 cycles", sec);
        end
        cnt_q.push_back('{20'd9, 32'hFFFF_FFFF, 1'b0});
        cnt_q.push_back('{20'd9, 32'hFFFF_FFFF, 1'b0});
        cnt_q.push_back('{20'd9, 32'hFFFF_FFFF, 1'b0});
        cnt_q.push_back('{20'd0, 32'h0, 1'b1});
        cnt_q.push_back('{20'd0, 32'h0, 1'b0});
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            e = cnt_q.pop_front();
            $display("wrap k=%0d usec=%0d sec=%h pps=%b", i, usec, sec, pps);
            n_cmp++;
            if ({usec, sec, pps} !== {e.u, e.s, e.p}) begin
                n_err++;
                $display("FAIL wrap k=%0d: got usec=%0d sec=%h pps=%b required usec=%0d sec=%h pps=%b",
                         i, usec, sec, pps, e.u, e.s, e.p);
            end
        end
    endtask

    task automatic test_corr();
        logic [31:0] inc_c;
        logic [31:0] acc_m;
        logic [32:0] s;
        logic        tick_m;
        int          cnt_m;
        int          cnt_d;
        bit          found;
        inc_c  = 32'h8000_0000 - 32'd32768;
        acc_m  = '0;
        tick_m = 1'b0;
        cnt_m  = 0;
        found  = 1'b0;
        wr(2'd2, 32'h0000_8000);
        wr(2'd0, 32'd0);
        wr(2'd1, 32'h5000);
        for (int i = 0; i < 12 && !found; i++) begin
            cyc();
            if (sec === 32'h5000) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL corr_apply: sec=%h required 5000 within 12 cycles", sec);
        end
        for (int i = 0; i < CORR_N; i++) begin
            cyc();
            if (tick_m) cnt_m++;
            s      = {1'b0, acc_m} + {1'b0, inc_c};
            acc_m  = s[31:0];
            tick_m = s[32];
        end
        cnt_d = int'(sec - 32'h5000) * (USEC_MAX + 1) + int'(usec);
        $display("corr: ticks=%0d model=%0d over %0d cycles", cnt_d, cnt_m, CORR_N);
        n_cmp++;
        if (cnt_d !== cnt_m) begin
            n_err++;
            $display("FAIL corr_ticks: got %0d required %0d", cnt_d, cnt_m);
        end
        wr(2'd2, 32'd0);
    endtask

    task automatic test_snapshot();
        cnt_t e;
        bit   found;
        found = 1'b0;
        wr(2'd0, 32'd0);
        wr(2'd1, 32'h200);
        for (int i = 0; i < 12 && !found; i++) begin
            cyc();
            if (sec === 32'h200) found = 1'b1;
        end
        apply_n = cyc_n;
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL snap_apply: sec=%h required 200 within 12 cycles", sec);
        end
        cyc(4);
        cnt_q.push_back(time_at(cyc_n - apply_n, 0, 32'h200));
        wr(2'd3, 32'd0);
        e = cnt_q.pop_front();
        $display("snap: usec=%0d sec=%h", bus.snap_usec, bus.snap_sec);
        n_cmp++;
        if ({bus.snap_usec, bus.snap_sec} !== {e.u, e.s}) begin
            n_err++;
            $display("FAIL snapshot: got %0d/%h required %0d/%h", bus.snap_usec, bus.snap_sec, e.u, e.s);
        end
    endtask

    task automatic test_overflow();
        cnt_t t;
        cap_t c;
        t = time_at(cyc_n - apply_n, 0, 32'h200);
        cap_q.push_back('{0, t.u, t.s});
        ev[0] = 1'b1; cyc(); ev[0] = 1'b0; cyc();
        n_cmp++;
        if ({ev_valid[0], ev_ovf[0]} !== 2'b10) begin
            n_err++;
            $display("FAIL ovf_first: valid/ovf=%b%b required 10", ev_valid[0], ev_ovf[0]);
        end
        cyc(3);
        ev[0] = 1'b1; cyc(); ev[0] = 1'b0; cyc();
        c = cap_q.pop_front();
        $display("ch0: valid=%b ovf=%b usec=%0d sec=%h", ev_valid[0], ev_ovf[0], ev_usec[19:0], ev_sec[31:0]);
        n_cmp++;
        if ({ev_valid[0], ev_ovf[0]} !== 2'b11) begin
            n_err++;
            $display("FAIL ovf_second: valid/ovf=%b%b required 11", ev_valid[0], ev_ovf[0]);
        end
        n_cmp++;
        if ({ev_usec[c.ch*20 +: 20], ev_sec[c.ch*32 +: 32]} !== {c.u, c.s}) begin
            n_err++;
            $display("FAIL ovf_data: got %0d/%h required %0d/%h",
                     ev_usec[c.ch*20 +: 20], ev_sec[c.ch*32 +: 32], c.u, c.s);
        end
        ev_ack[0] = 1'b1; cyc(); ev_ack[0] = 1'b0;
        n_cmp++;
        if ({ev_valid[0], ev_ovf[0]} !== 2'b00) begin
            n_err++;
            $display("FAIL ovf_ack: valid/ovf=%b%b required 00", ev_valid[0], ev_ovf[0]);
        end
    endtask

    task automatic test_ack_edge();
        cnt_t t;
        cap_t c;
        t = time_at(cyc_n - apply_n, 0, 32'h200);
        cap_q.push_back('{1, t.u, t.s});
        ev[1] = 1'b1; cyc(); ev[1] = 1'b0; cyc();
        ev[1] = 1'b1; cyc(); ev[1] = 1'b0; cyc();
        c = cap_q.pop_front();
        n_cmp++;
        if ({ev_ovf[1], ev_usec[c.ch*20 +: 20], ev_sec[c.ch*32 +: 32]} !== {1'b1, c.u, c.s}) begin
            n_err++;
            $display("FAIL ackedge_pre: ovf=%b data=%0d/%h required 1 %0d/%h",
                     ev_ovf[1], ev_usec[c.ch*20 +: 20], ev_sec[c.ch*32 +: 32], c.u, c.s);
        end
        cyc(3);
        t = time_at(cyc_n - apply_n, 0, 32'h200);
        cap_q.push_back('{1, t.u, t.s});
        cap_q.push_back('{2, t.u, t.s});
        ev[1] = 1'b1; ev[2] = 1'b1; ev_ack[1] = 1'b1;
        cyc();
        ev[1] = 1'b0; ev[2] = 1'b0; ev_ack[1] = 1'b0;
        $display("ch1/ch2: valid=%b ovf=%b", ev_valid, ev_ovf);
        n_cmp++;
        if ({ev_valid[2:1], ev_ovf[2:1]} !== 4'b1100) begin
            n_err++;
            $display("FAIL ackedge_flags: valid=%b ovf=%b required 11/00", ev_valid[2:1], ev_ovf[2:1]);
        end
        while (cap_q.size() > 0) begin
            c = cap_q.pop_front();
            n_cmp++;
            if ({ev_usec[c.ch*20 +: 20], ev_sec[c.ch*32 +: 32]} !== {c.u, c.s}) begin
                n_err++;
                $display("FAIL ackedge_data ch%0d: got %0d/%h required %0d/%h", c.ch,
                         ev_usec[c.ch*20 +: 20], ev_sec[c.ch*32 +: 32], c.u, c.s);
            end
        end
    endtask

    task automatic test_reset_mid();
        cap_t c;
        ev = 4'hF; cyc(); ev = 4'h0;
        n_cmp++;
        if (ev_valid !== 4'hF) begin
            n_err++;
            $display("FAIL rstmid_valid: got %b required 1111", ev_valid);
        end
        wr(2'd0, 32'd5);
        wr(2'd1, 32'h300);
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset mid-run: usec=%0d sec=%h enabled=%b valid=%b", usec, sec, enabled, ev_valid);
        n_cmp++;
        if ({usec, sec, pps, enabled} !== 54'd0) begin
            n_err++;
            $display("FAIL rstmid_time: usec=%0d sec=%h pps=%b en=%b required all 0", usec, sec, pps, enabled);
        end
        n_cmp++;
        if ({ev_valid, ev_ovf, ev_sec, ev_usec, bus.snap_usec, bus.snap_sec} !== '0) begin
            n_err++;
            $display("FAIL rstmid_ev: valid=%b ovf=%b sec0=%h snap=%h required all 0",
                     ev_valid, ev_ovf, ev_sec[31:0], bus.snap_sec);
        end
        cyc(3);
        @(negedge mclk);
        rst_n = 1'b1;
        cyc(30);
        n_cmp++;
        if ({enabled, usec, sec} !== 53'd0) begin
            n_err++;
            $display("FAIL rstmid_noset: en=%b usec=%0d sec=%h required 0", enabled, usec, sec);
        end
        cap_q.push_back('{3, 20'd0, 32'd0});
        ev[3] = 1'b1; cyc(); ev[3] = 1'b0;
        c = cap_q.pop_front();
        $display("disabled capture ch3: valid=%b usec=%0d sec=%h", ev_valid[3], ev_usec[79:60], ev_sec[127:96]);
        n_cmp++;
        if ({ev_valid[c.ch], ev_usec[c.ch*20 +: 20], ev_sec[c.ch*32 +: 32]} !== {1'b1, c.u, c.s}) begin
            n_err++;
            $display("FAIL disabled_cap: valid=%b data=%0d/%h required 1 %0d/%h", ev_valid[c.ch],
                     ev_usec[c.ch*20 +: 20], ev_sec[c.ch*32 +: 32], c.u, c.s);
        end
    endtask

    initial begin
        bus.we = 1'b0;
        bus.wa = 2'd0;
        bus.wd = 32'd0;
        test_reset();
        test_set();
        test_wrap();
        test_corr();
        test_snapshot();
        test_overflow();
        test_ack_edge();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
